// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcodes, ALU codes, FSM states.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

   // Default program-counter / address width of the 13-bit datapath
   localparam int DEF_PC_W = 13;

   // Instruction opcodes as presented by the decoder
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_LOAD  = 3'b101;
   localparam logic [2:0] OP_STORE = 3'b110;
   localparam logic [2:0] OP_BEQ   = 3'b111;

   // ALU operation selects
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // Control FSM states (3-bit encoding)
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   // ALU op for an opcode: address calc for ADDI/LOAD/STORE is an add, BEQ compares by subtract
   function automatic logic [2:0] alu_of(input logic [2:0] op);
      logic [2:0] a;
      a = ALU_ADD;
      case (op)
         OP_SUB, OP_BEQ: a = ALU_SUB;
         OP_AND:         a = ALU_AND;
         OP_OR:          a = ALU_OR;
         default:        a = ALU_ADD;
      endcase
      return a;
   endfunction

   // True when operand 2 is the sign-extended immediate rather than a register
   function automatic logic uses_imm(input logic [2:0] op);
      return (op == OP_ADDI) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_done in a memory-wait state and flags a timeout.
// Latency: expired is combinational on the current count; count updates each clock.
// Backpressure: none; mem_done in the limit cycle suppresses expired so completion wins.
module mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic clr,
   input  logic mem_done,
   output logic expired
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Count wait cycles without completion; restart on every state change or outside a wait
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr || !active) begin
         cnt <= '0;
      end else if (!mem_done && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   // The limit cycle is the MEM_TIMEOUT-th consecutive cycle without mem_done
   always_comb begin
      expired = active && !mem_done && (cnt == CW'(MEM_TIMEOUT - 1));
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/(MEM)/WRITEBACK, owns PC, drives datapath strobes.
// Latency: ALU 5, LOAD 7, STORE 6, BEQ 4 cycles with a memory answering one cycle after the strobe.
// Backpressure: strobes held until mem_done; no answer within MEM_TIMEOUT cycles -> sticky FAULT.
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter int              PC_W        = DEF_PC_W,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            mem_done,
   input  logic [2:0]      opcode,
   input  logic            beq,
   input  logic [PC_W-1:0] new_pc,
   output logic            read,
   output logic            write,
   output logic            instruction,
   output logic            instruction_type,
   output logic [2:0]      alu_op,
   output logic            write_flag,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            fault
);

   state_t          state_q;
   state_t          state_d;
   logic [2:0]      op_q;
   logic [2:0]      op_d;
   logic [PC_W-1:0] pc_d;
   logic            wait_active;
   logic            wait_clr;
   logic            wait_expired;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .active   (wait_active),
      .clr      (wait_clr),
      .mem_done (mem_done),
      .expired  (wait_expired)
   );

   // Timer runs only in the two states that wait on memory; any transition restarts it
   always_comb begin
      wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
      wait_clr    = (state_d != state_q);
   end

   // Opcode register loads in DECODE; op_d lets outputs for EXECUTE see the new opcode at once
   always_comb begin
      op_d = op_q;
      if (state_q == S_DECODE) begin
         op_d = opcode;
      end
   end

   // Next-state and next-PC logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_done) begin
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            case (op_q)
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_BEQ: begin
                  state_d = S_FETCH;
                  pc_d    = beq ? new_pc : pc + PC_W'(1);
               end
               default: state_d = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            if (mem_done) begin
               if (op_q == OP_LOAD) begin
                  state_d = S_WRITEBACK;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = pc + PC_W'(1);
               end
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end
         end
         S_WRITEBACK: begin
            state_d = S_FETCH;
            pc_d    = pc + PC_W'(1);
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   // State, PC and opcode registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc      <= RESET_PC;
         op_q    <= OP_ADD;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         op_q    <= op_d;
      end
   end

   // Operand-2 mux select is captured with the opcode and held until the next DECODE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction_type <= 1'b1;
      end else if (state_q == S_DECODE) begin
         instruction_type <= !uses_imm(opcode);
      end
   end

   // Moore outputs registered from the next state so they line up with state_q
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read        <= 1'b0;
         write       <= 1'b0;
         instruction <= 1'b0;
         alu_op      <= ALU_ADD;
         write_flag  <= 1'b0;
         halted      <= 1'b1;
         fault       <= 1'b0;
      end else begin
         read        <= (state_d == S_FETCH) || ((state_d == S_MEM) && (op_d == OP_LOAD));
         write       <= (state_d == S_MEM) && (op_d == OP_STORE);
         instruction <= (state_d == S_FETCH);
         alu_op      <= ((state_d == S_EXECUTE) || (state_d == S_MEM) ||
                         (state_d == S_WRITEBACK)) ? alu_of(op_d) : ALU_ADD;
         write_flag  <= (state_d == S_WRITEBACK);
         halted      <= (state_d == S_IDLE) || (state_d == S_FAULT);
         fault       <= (state_d == S_FAULT);
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench: per-instruction expected output schedule, compared at every falling edge.
// Latency: n/a.
// Backpressure: memory answers are scripted per instruction (done delay in FETCH and MEM).
module tb_cpu_control_fsm;

   logic        clk;
   logic        reset;
   logic        run;
   logic        mem_done;
   logic [2:0]  opcode;
   logic        beq;
   logic [12:0] new_pc;
   logic        read;
   logic        write;
   logic        instruction;
   logic        instruction_type;
   logic [2:0]  alu_op;
   logic        write_flag;
   logic [12:0] pc;
   logic        halted;
   logic        fault;

   cpu_control_fsm dut (
      .clk              (clk),
      .reset            (reset),
      .run              (run),
      .mem_done         (mem_done),
      .opcode           (opcode),
      .beq              (beq),
      .new_pc           (new_pc),
      .read             (read),
      .write            (write),
      .instruction      (instruction),
      .instruction_type (instruction_type),
      .alu_op           (alu_op),
      .write_flag       (write_flag),
      .pc               (pc),
      .halted           (halted),
      .fault            (fault)
   );

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        ins;
      logic        ity;
      logic [2:0]  alu;
      logic        wf;
      logic [12:0] pc;
      logic        hlt;
      logic        flt;
   } exp_t;

   int   total  = 0;
   int   passed = 0;
   logic chk_en;
   exp_t ex;
   exp_t rst_e;

   // Model state: architectural PC and the operand-2 select of the last decoded instruction
   logic [12:0] m_pc;
   logic        m_itype;
   logic [2:0]  alu_tab [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Single compare process against the model's expectation for the current cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("read",             32'(read),             32'(ex.rd));
         chk("write",            32'(write),            32'(ex.wr));
         chk("instruction",      32'(instruction),      32'(ex.ins));
         chk("instruction_type", 32'(instruction_type), 32'(ex.ity));
         chk("alu_op",           32'(alu_op),           32'(ex.alu));
         chk("write_flag",       32'(write_flag),       32'(ex.wf));
         chk("pc",               32'(pc),               32'(ex.pc));
         chk("halted",           32'(halted),           32'(ex.hlt));
         chk("fault",            32'(fault),            32'(ex.flt));
         chk("rd_wr_exclusive",  32'(read & write),     32'(0));
      end
   end

   function automatic exp_t mk(input logic rd, input logic wr, input logic ins,
                               input logic [2:0] alu, input logic wf);
      exp_t e;
      e.rd  = rd;
      e.wr  = wr;
      e.ins = ins;
      e.ity = m_itype;
      e.alu = alu;
      e.wf  = wf;
      e.pc  = m_pc;
      e.hlt = 1'b0;
      e.flt = 1'b0;
      return e;
   endfunction

   // Advance one cycle, then present this cycle's inputs and expected outputs
   task automatic drv(input exp_t e, input logic md, input logic [2:0] opc);
      @(posedge clk);
      #1;
      mem_done = md;
      opcode   = opc;
      ex       = e;
      chk_en   = 1'b1;
   endtask

   // One instruction: fd/md = cycles before mem_done in FETCH/MEM; opcode valid only in DECODE
   task automatic do_instr(input logic [2:0] op, input int fd, input int md,
                           input logic b, input logic [12:0] npc, input logic dnoise,
                           input logic [12:0] pin_pc);
      logic [2:0] a;
      for (int k = 0; k <= fd; k++) begin
         drv(mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0), (k == fd), ~op);
         if (k == 0) chk("pc_literal", 32'(pc), 32'(pin_pc));
         beq    = ~b;
         new_pc = ~npc;
      end
      drv(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0), dnoise, op);
      m_itype = !(op inside {3'd4, 3'd5, 3'd6});
      a       = alu_tab[op];
      drv(mk(1'b0, 1'b0, 1'b0, a, 1'b0), 1'b0, ~op);
      beq    = b;
      new_pc = npc;
      if (op == 3'd7) begin
         m_pc = b ? npc : m_pc + 13'd1;
      end else if (op == 3'd5 || op == 3'd6) begin
         for (int k = 0; k <= md; k++) begin
            drv(mk((op == 3'd5), (op == 3'd6), 1'b0, a, 1'b0), (k == md), ~op);
            beq = ~b;
         end
         if (op == 3'd5) drv(mk(1'b0, 1'b0, 1'b0, a, 1'b1), 1'b0, ~op);
         m_pc = m_pc + 13'd1;
      end else begin
         drv(mk(1'b0, 1'b0, 1'b0, a, 1'b1), 1'b0, ~op);
         m_pc = m_pc + 13'd1;
      end
   endtask

   // Never-answering fetch: 15 strobed cycles, then the sticky fault state
   task automatic do_fault(input logic [12:0] pin_pc);
      exp_t e;
      for (int k = 0; k < 15; k++) begin
         drv(mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0), 1'b0, 3'd0);
         if (k == 0) chk("fault_pc_literal", 32'(pc), 32'(pin_pc));
      end
      e     = '0;
      e.pc  = m_pc;
      e.ity = m_itype;
      e.hlt = 1'b1;
      e.flt = 1'b1;
      for (int k = 0; k < 4; k++) drv(e, (k == 1), 3'd0);
      chk("fault_literal", 32'(fault), 32'(1));
      chk("fault_read_literal", 32'(read), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      alu_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1};
      rst_e   = '0;
      rst_e.ity = 1'b1;
      rst_e.hlt = 1'b1;
      reset    = 1'b1;
      run      = 1'b0;
      mem_done = 1'b0;
      opcode   = 3'd0;
      beq      = 1'b0;
      new_pc   = 13'd0;
      chk_en   = 1'b0;
      ex       = rst_e;
      m_pc     = 13'd0;
      m_itype  = 1'b1;

      drv(rst_e, 1'b0, 3'd0);
      drv(rst_e, 1'b1, 3'd0);
      reset = 1'b0;
      chk("halted_reset_literal", 32'(halted), 32'(1));
      chk("pc_reset_literal", 32'(pc), 32'(0));
      chk("itype_reset_literal", 32'(instruction_type), 32'(1));
      drv(rst_e, 1'b0, 3'd0);
      run = 1'b1;

      do_instr(3'd0, 1, 0, 1'b0, 13'h000, 1'b0, 13'h0000);   // ADD
      run = 1'b0;
      do_instr(3'd4, 1, 0, 1'b0, 13'h000, 1'b1, 13'h0001);   // ADDI, stray mem_done in DECODE
      do_instr(3'd1, 0, 0, 1'b0, 13'h000, 1'b0, 13'h0002);   // SUB, instant fetch
      do_instr(3'd7, 1, 0, 1'b1, 13'h0A5, 1'b0, 13'h0003);   // BEQ taken
      do_instr(3'd7, 1, 0, 1'b0, 13'h123, 1'b0, 13'h00A5);   // BEQ not taken
      do_instr(3'd5, 1, 3, 1'b0, 13'h000, 1'b0, 13'h00A6);   // LOAD, slow memory
      do_instr(3'd2, 1, 0, 1'b0, 13'h000, 1'b0, 13'h00A7);   // AND
      do_instr(3'd3, 2, 0, 1'b0, 13'h000, 1'b0, 13'h00A8);   // OR
      do_instr(3'd7, 1, 0, 1'b1, 13'h1FFF, 1'b0, 13'h00A9);  // BEQ to top of memory
      do_instr(3'd6, 1, 2, 1'b0, 13'h000, 1'b0, 13'h1FFF);   // STORE, PC wraps
      do_instr(3'd0, 14, 0, 1'b0, 13'h000, 1'b0, 13'h0000);  // done exactly at the limit
      do_fault(13'h0001);

      @(posedge clk);
      #1;
      reset   = 1'b1;
      ex      = rst_e;
      m_pc    = 13'd0;
      m_itype = 1'b1;
      drv(rst_e, 1'b0, 3'd0);
      reset = 1'b0;
      chk("fault_cleared_literal", 32'(fault), 32'(0));
      drv(rst_e, 1'b0, 3'd0);
      run = 1'b1;

      // SUB interrupted by reset in EXECUTE
      for (int k = 0; k <= 1; k++) drv(mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0), (k == 1), 3'd6);
      run = 1'b0;
      drv(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'd1);
      @(posedge clk);
      #1;
      chk("alu_exec_literal", 32'(alu_op), 32'(1));
      chk("itype_exec_literal", 32'(instruction_type), 32'(1));
      reset = 1'b1;
      ex    = rst_e;
      drv(rst_e, 1'b0, 3'd0);
      reset = 1'b0;
      drv(rst_e, 1'b0, 3'd0);
      drv(rst_e, 1'b0, 3'd0);
      chk("no_partial_wf_literal", 32'(write_flag), 32'(0));
      chk("pc_after_reset_literal", 32'(pc), 32'(0));
      @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
